// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end for the 5-stage RISC-V pipeline. It replaces the
// single PC register and IF/ID latch with a DEPTH-entry prefetch queue of
// {pc, instr} pairs. It issues one sequential fetch per cycle to a synchronous
// instruction memory while queue credit remains. It hands the queue head to
// decode through a valid/ready handshake. An EX-stage redirect flushes
// everything and restarts fetch at the new target.
//
// Handshake (decode side): if_valid/if_pc/if_instr are presented by this block.
// An entry transfers on a cycle where if_valid=1 and id_ready=1 (a "pop").
// While if_valid=1 and id_ready=0 the head entry and if_pc/if_instr stay
// stable. if_valid never depends on id_ready.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high
//   imem_req       fetch request this cycle
//   imem_addr      fetch address (valid when imem_req=1)
//   imem_rdata     instruction, valid the cycle after imem_req=1
//   redirect_valid taken branch/jump from EX, flushes the front end
//   redirect_pc    new fetch address, bits [1:0] treated as 0
//   if_valid       head entry presented to decode
//   if_pc          PC of head entry (holds last head value when empty)
//   if_instr       instruction of head entry (holds last head value when empty)
//   id_ready       decode accepts, 0 = hazard stall
//   occupancy      entries currently held in the queue
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int                PC_W     = 9,
  parameter int                INS_W    = 32,
  parameter int                DEPTH    = 4,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       if_valid,
  output logic [PC_W-1:0]            if_pc,
  output logic [INS_W-1:0]           if_instr,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so count + inflight cannot wrap before the compare.
  localparam int SUM_W = CNT_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]  fetch_pc;     // address of the next request
  logic             inflight;     // 1 = a response is due this cycle
  logic [PC_W-1:0]  req_pc;       // PC of the request currently in flight
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Last presented head, shown to decode while the queue is empty.
  logic [PC_W-1:0]  hold_pc;
  logic [INS_W-1:0] hold_instr;

  // Queue storage. It is never cleared, because only pointers and count
  // define which entries are live.
  logic [PC_W-1:0]  q_pc    [DEPTH];
  logic [INS_W-1:0] q_instr [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             queue_nonempty;
  logic             pop;
  logic             push;
  logic [SUM_W-1:0] credit_used;
  logic [PC_W-1:0]  redirect_aligned;

  assign queue_nonempty = (count != '0);

  // Redirect hides the head in the same cycle, so nothing is consumed from a
  // queue that is about to be flushed.
  assign if_valid = queue_nonempty & ~redirect_valid;
  assign pop      = if_valid & id_ready;

  // A response that lands in a redirect or reset cycle belongs to the old
  // stream and is dropped.
  assign push = inflight & ~redirect_valid & ~reset;

  // Credit counts the entries held plus the one in flight. It also counts the
  // pop of this cycle, so a draining decode keeps one fetch per cycle going
  // even when the queue is full.
  assign credit_used = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);

  assign imem_req  = ~reset & ~redirect_valid & (credit_used < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc;

  // Instructions are word aligned, so the low two bits of the target are
  // forced to zero.
  assign redirect_aligned = redirect_pc & ~PC_W'(3);

  assign occupancy = count;

  always_comb begin
    if_pc    = hold_pc;
    if_instr = hold_instr;
    if (queue_nonempty) begin
      if_pc    = q_pc[rd_ptr];
      if_instr = q_instr[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: fetch PC, inflight flag, pointers, count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      // Keep a copy of the visible head so the outputs hold after it drains.
      if (queue_nonempty) begin
        hold_pc    <= q_pc[rd_ptr];
        hold_instr <= q_instr[rd_ptr];
      end

      if (redirect_valid) begin
        // Flush: a later redirect simply overwrites an earlier one, so the
        // last redirect wins.
        fetch_pc <= redirect_aligned;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + PC_W'(4);  // wraps modulo 2**PC_W
        end
        inflight <= imem_req;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        // When push and pop happen together, count stays the same,
        // and this holds even when the queue is full.
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data path: request PC tracking and queue writes (no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (imem_req) begin
      req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= req_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Bench for fetch_queue_unit. The instruction memory model returns a word made
// from the fetch address and a stream "epoch". The epoch changes on every reset
// and redirect, so an instruction that leaks from a flushed stream cannot match
// the expected value.
//
// Reference model: after a reset or redirect, decode must receive the
// consecutive word addresses that start at the restart PC, in order and with
// none missing or repeated. The expected queue is refilled from that rule. A
// monitor compares each accepted handshake against the head of the queue.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic              clk;
  logic              reset;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INS_W-1:0]  imem_rdata;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INS_W-1:0]  if_instr;
  logic              id_ready;
  logic [OCC_W-1:0]  occupancy;

  fetch_queue_unit #(
    .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .occupancy(occupancy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [7:0] epoch;

  function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a, input logic [7:0] ep);
    return {ep, 15'h2A5A, a};
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr, epoch);
  end

  // ---------------- scoreboard state ----------------
  logic [PC_W+INS_W-1:0] exp_q[$];
  logic [PC_W-1:0]       model_pc;
  int                    n_checks;
  int                    n_errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back({model_pc, mem_word(model_pc, epoch)});
      model_pc = model_pc + PC_W'(4);
    end
  endtask

  // A new stream starts at pc; everything queued for the old stream is gone.
  task automatic restart(input logic [PC_W-1:0] pc);
    epoch = epoch + 8'd1;
    exp_q.delete();
    model_pc = pc;
    topup();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic            hold_prev;
  logic [PC_W-1:0] hold_pc_s;
  logic [INS_W-1:0] hold_instr_s;
  logic [PC_W+INS_W-1:0] e;

  initial hold_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("occupancy_bound", 64'(occupancy > OCC_W'(DEPTH)), 64'(0));
      if (hold_prev && !redirect_valid) begin
        chk("stall_valid", 64'(if_valid), 64'(1));
        chk("stall_pc", 64'(if_pc), 64'(hold_pc_s));
        chk("stall_instr", 64'(if_instr), 64'(hold_instr_s));
      end
      if (if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", 64'(if_pc), 64'(e[PC_W+INS_W-1:INS_W]));
          chk("pop_instr", 64'(if_instr), 64'(e[INS_W-1:0]));
          topup();
        end
      end
      hold_prev    = if_valid && !id_ready;
      hold_pc_s    = if_pc;
      hold_instr_s = if_instr;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic [PC_W-1:0] exp_addr [4];
  logic [PC_W-1:0] rpc;
  int r;

  initial begin
    n_checks = 0;
    n_errors = 0;
    epoch = 8'd0;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    restart(RESET_PC);

    // 1: reset state, then sequential fetch and 2-cycle fetch-to-decode latency
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_if_valid", 64'(if_valid), 64'(0));
    chk("rst_imem_req", 64'(imem_req), 64'(0));
    chk("rst_if_pc", 64'(if_pc), 64'(0));
    chk("rst_if_instr", 64'(if_instr), 64'(0));
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("seq_req", 64'(imem_req), 64'(1));
      chk("seq_addr", 64'(imem_addr), 64'(RESET_PC + PC_W'(4 * k)));
      chk("seq_if_valid", 64'(if_valid), 64'(k >= 2));
      if (k >= 2) chk("seq_if_pc", 64'(if_pc), 64'(RESET_PC + PC_W'(4 * (k - 2))));
      cyc();
    end

    // 2: stall from the start fills the queue, then it drains without a gap
    reset = 1'b1;
    id_ready = 1'b0;
    restart(RESET_PC);
    cyc();
    reset = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
    chk("full_no_req", 64'(imem_req), 64'(0));
    chk("full_if_pc", 64'(if_pc), 64'(RESET_PC));
    chk("full_if_valid", 64'(if_valid), 64'(1));
    cyc();
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("drain_no_gap", 64'(if_valid), 64'(1));
      cyc();
    end

    // 3: redirect while stalled with a response in flight
    reset = 1'b1;
    id_ready = 1'b0;
    restart(RESET_PC);
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 9'h043;
    restart(9'h040);
    @(negedge clk);
    chk("redir_if_valid", 64'(if_valid), 64'(0));
    chk("redir_imem_req", 64'(imem_req), 64'(0));
    cyc();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("redir_occupancy", 64'(occupancy), 64'(0));
    chk("redir_req", 64'(imem_req), 64'(1));
    chk("redir_addr", 64'(imem_addr), 64'(9'h040));
    chk("redir_pen1", 64'(if_valid), 64'(0));
    cyc();
    @(negedge clk);
    chk("redir_pen2", 64'(if_valid), 64'(0));
    cyc();
    @(negedge clk);
    chk("redir_first_valid", 64'(if_valid), 64'(1));
    chk("redir_first_pc", 64'(if_pc), 64'(9'h040));
    cyc();

    // 4: PC wraps modulo 2**PC_W
    redirect_valid = 1'b1;
    redirect_pc = 9'h1F8;
    restart(9'h1F8);
    cyc();
    redirect_valid = 1'b0;
    exp_addr[0] = 9'h1F8;
    exp_addr[1] = 9'h1FC;
    exp_addr[2] = 9'h000;
    exp_addr[3] = 9'h004;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wrap_addr", 64'(imem_addr), 64'(exp_addr[k]));
      cyc();
    end

    // 5: full queue, one pop refills back to DEPTH and nothing is lost
    id_ready = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    chk("refill_full", 64'(occupancy), 64'(DEPTH));
    cyc();
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    @(negedge clk);
    chk("refill_mid", 64'(occupancy), 64'(DEPTH - 1));
    cyc();
    @(negedge clk);
    chk("refill_back", 64'(occupancy), 64'(DEPTH));
    cyc();

    // 6: reset mid-stream with a response in flight
    id_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("pre_reset_req", 64'(imem_req), 64'(1));
    cyc();
    reset = 1'b1;
    restart(RESET_PC);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_occupancy", 64'(occupancy), 64'(0));
    chk("midrst_if_valid", 64'(if_valid), 64'(0));
    chk("midrst_addr", 64'(imem_addr), 64'(RESET_PC));
    chk("midrst_req", 64'(imem_req), 64'(1));
    cyc();
    repeat (6) cyc();

    // Random phase: stalls, redirects (including back-to-back) and resets
    for (int n = 0; n < 3000; n++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 4) begin
        rpc = PC_W'($urandom);
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = rpc;
        restart(rpc & ~PC_W'(3));
      end else if (r == 4) begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        restart(RESET_PC);
      end else begin
        reset = 1'b0;
        redirect_valid = 1'b0;
      end
      cyc();
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
